// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle sequencer: opcodes, ALU codes, FSM states,
// trap causes and the instruction decoder used by the sequencer.
package cpu_pkg;

    localparam logic [5:0] OP_ALU = 6'd6;
    localparam logic [5:0] OP_LW  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    localparam logic [5:0] F_ADD  = 6'd32;
    localparam logic [5:0] F_SUB  = 6'd34;
    localparam logic [5:0] F_AND  = 6'd36;
    localparam logic [5:0] F_OR   = 6'd37;
    localparam logic [5:0] F_MULT = 6'd50;

    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_MULT = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_IMEM    = 2'd2;
    localparam logic [1:0] TRAP_DMEM    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       sel_imm;
        logic       sel_mem;
        logic [2:0] alu_op;
        logic       nop;
        logic       legal;
        logic       mem;
        logic       sw;
        logic       mult;
    } ctrl_t;

    // legal=1 means the word may proceed past DECODE (NOP included).
    function automatic ctrl_t decode(input logic [31:0] w);
        ctrl_t c;
        c     = '0;
        c.rs  = w[25:21];
        c.rt  = w[20:16];
        c.rd  = w[15:11];
        c.nop = (w == 32'd0);
        case (w[31:26])
            OP_ALU: begin
                case (w[5:0])
                    F_ADD:   c.alu_op = ALU_ADD;
                    F_SUB:   c.alu_op = ALU_SUB;
                    F_MULT:  c.alu_op = ALU_MULT;
                    F_AND:   c.alu_op = ALU_AND;
                    F_OR:    c.alu_op = ALU_OR;
                    default: c.alu_op = ALU_NOP;
                endcase
                c.legal = (c.alu_op != ALU_NOP);
                c.mult  = (c.alu_op == ALU_MULT);
            end
            OP_LW: begin
                c.legal   = 1'b1;
                c.mem     = 1'b1;
                c.sel_imm = 1'b1;
                c.sel_mem = 1'b1;
                c.alu_op  = ALU_ADD;
                c.rd      = w[20:16];
            end
            OP_SW: begin
                c.legal   = 1'b1;
                c.mem     = 1'b1;
                c.sw      = 1'b1;
                c.sel_imm = 1'b1;
                c.alu_op  = ALU_ADD;
            end
            default: c.legal = c.nop;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Down-counter shared by the MULT stall and the memory-ack timeout.
// expire is high during the last cycle of a window that was loaded with load_val.
module seq_timeout_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback, with traps.
// Handshake: imem_req/dmem_req rise on entry and stay high until the cycle an ack is sampled, or until timeout.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int AW          = 8,
    parameter int MULT_LAT    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          dmem_req,
    output logic          dmem_we,
    input  logic          dmem_ack,
    output logic [4:0]    rf_rs,
    output logic [4:0]    rf_rt,
    output logic [4:0]    rf_rd,
    output logic          rf_we,
    output logic          sel_imm,
    output logic          sel_mem,
    output logic [2:0]    alu_op,
    output logic          halted,
    output logic [1:0]    trap_cause,
    output logic [15:0]   retired,
    output state_t        dbg_state
);

    localparam int CMAX = (MULT_LAT > MEM_TIMEOUT) ? MULT_LAT : MEM_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state;
    state_t        nxt;
    logic [AW-1:0] pc;
    logic [31:0]   ir;
    ctrl_t         dec;
    logic          expire;
    logic          retire;
    logic          load;
    logic          active;
    logic [CW-1:0] load_val;
    logic [1:0]    trap_next;

    // While fetching, decode the incoming word so control outputs are ready in DECODE.
    assign dec       = decode((state == S_FETCH) ? imem_rdata : ir);
    assign imem_addr = pc;
    assign dbg_state = state;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (run) nxt = S_FETCH;
            S_FETCH:  if (imem_ack) nxt = S_DECODE;
                      else if (expire) nxt = S_HALT;
            S_DECODE: if (dec.nop) nxt = S_FETCH;
                      else if (dec.legal) nxt = S_EXEC;
                      else nxt = S_HALT;
            S_EXEC:   if (expire) nxt = dec.mem ? S_MEM : S_WB;
            S_MEM:    if (dmem_ack) nxt = dec.sw ? S_FETCH : S_WB;
                      else if (expire) nxt = S_HALT;
            S_WB:     nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        retire   = ((state == S_DECODE) && dec.nop) ||
                   ((state == S_MEM) && dmem_ack && dec.sw) ||
                   (state == S_WB);
        load     = (nxt != state);
        load_val = (nxt == S_EXEC) ? (dec.mult ? CW'(MULT_LAT) : CW'(1)) : CW'(MEM_TIMEOUT);
        active   = (nxt == S_DECODE) || (nxt == S_EXEC) || (nxt == S_MEM) || (nxt == S_WB);
        if (state == S_FETCH)    trap_next = TRAP_IMEM;
        else if (state == S_MEM) trap_next = TRAP_DMEM;
        else                     trap_next = TRAP_ILLEGAL;
    end

    seq_timeout_ctr #(.W(CW)) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            retired    <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            rf_we      <= 1'b0;
            rf_rs      <= '0;
            rf_rt      <= '0;
            rf_rd      <= '0;
            sel_imm    <= 1'b0;
            sel_mem    <= 1'b0;
            alu_op     <= ALU_NOP;
            halted     <= 1'b0;
            trap_cause <= TRAP_NONE;
        end else begin
            state <= nxt;
            if ((state == S_FETCH) && imem_ack) ir <= imem_rdata;
            if (retire) begin
                pc      <= pc + 1'b1;
                retired <= retired + 16'd1;
            end
            imem_req <= (nxt == S_FETCH);
            dmem_req <= (nxt == S_MEM);
            dmem_we  <= (nxt == S_MEM) && dec.sw;
            rf_we    <= (nxt == S_WB);
            halted   <= (nxt == S_HALT);
            if ((state != S_HALT) && (nxt == S_HALT)) trap_cause <= trap_next;
            // Datapath controls hold from DECODE through WB and clear elsewhere.
            rf_rs   <= active ? dec.rs : 5'd0;
            rf_rt   <= active ? dec.rt : 5'd0;
            rf_rd   <= active ? dec.rd : 5'd0;
            sel_imm <= active && dec.sel_imm;
            sel_mem <= active && dec.sel_mem;
            alu_op  <= active ? dec.alu_op : ALU_NOP;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed programs, memory responders, event monitor and expected-event queue.
module tb_multicycle_sequencer;
    import cpu_pkg::*;

    localparam int AW = 8;
    localparam int MULT_LAT = 4;
    localparam int MEM_TIMEOUT = 15;
    localparam int NEVER = 1000;
    localparam logic [3:0] EV_EXEC = 4'd3, EV_MEM = 4'd1, EV_WB = 4'd2, EV_HALT = 4'd4;
    localparam logic [31:0] ILL = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [4:0] rf_rs, rf_rt, rf_rd;
    logic rf_we, sel_imm, sel_mem, halted;
    logic [2:0] alu_op;
    logic [1:0] trap_cause;
    logic [15:0] retired;
    state_t dbg_state;

    logic [31:0] prog [256];
    int imem_lat = 0, dmem_lat = 0, icnt = 0, dcnt = 0;
    int n_vec = 0, n_err = 0;
    logic [35:0] exp_q[$];

    multicycle_sequencer #(.AW(AW), .MULT_LAT(MULT_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd(rf_rd), .rf_we(rf_we),
        .sel_imm(sel_imm), .sel_mem(sel_mem), .alu_op(alu_op),
        .halted(halted), .trap_cause(trap_cause), .retired(retired), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [35:0] mk(input logic [3:0] t, input logic [15:0] a, input logic [15:0] b);
        return {t, a, b};
    endfunction
    function automatic logic [35:0] ev_exec(input logic [2:0] op, input int len);
        return mk(EV_EXEC, {13'd0, op}, 16'(len));
    endfunction
    function automatic logic [35:0] ev_mem(input logic we, input logic si, input logic sm, input logic [2:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs, input logic [7:0] addr,
                                           input int len);
        return mk(EV_MEM, {we, si, sm, op, rd, rs}, {addr, 8'(len)});
    endfunction
    function automatic logic [35:0] ev_wb(input logic si, input logic sm, input logic [2:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [7:0] addr, input int ret);
        return mk(EV_WB, {1'b0, si, sm, op, rd, rs}, {addr, 8'(ret)});
    endfunction
    function automatic logic [35:0] ev_halt(input logic [1:0] cause, input logic [7:0] addr, input int ret);
        return mk(EV_HALT, {14'd0, cause}, {addr, 8'(ret)});
    endfunction
    function automatic logic [31:0] alu_w(input int rs, input int funct);
        return {6'd6, 5'(rs), 5'(rs + 1), 5'(rs + 2), 5'd0, 6'(funct)};
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic check_ev(input string nm, input logic [35:0] got);
        logic [35:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got event %h but none expected", nm, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: got event %h expected %h", nm, got, e);
            end
        end
    endtask

    // Memory responders: ack after a programmable number of request cycles.
    always @(negedge clk) begin
        if (imem_req) begin
            imem_ack = (icnt == imem_lat);
            icnt++;
        end else begin
            imem_ack = 1'b0;
            icnt = 0;
        end
        imem_rdata = prog[imem_addr];
        if (dmem_req) begin
            dmem_ack = (dcnt == dmem_lat);
            dcnt++;
        end else begin
            dmem_ack = 1'b0;
            dcnt = 0;
        end
    end

    // Monitor: turns DUT activity into events and checks them against the queue.
    logic prev_dmem = 1'b0, prev_halted = 1'b0;
    int exec_len = 0, mem_len = 0;
    logic [2:0] exec_op = 3'd0;
    logic [15:0] mem_a = 16'd0;
    logic [7:0] mem_addr = 8'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dmem = 1'b0; prev_halted = 1'b0; exec_len = 0; mem_len = 0;
        end else begin
            if (dbg_state == S_EXEC) begin
                exec_len++;
                exec_op = alu_op;
            end else if (exec_len != 0) begin
                check_ev("exec", mk(EV_EXEC, {13'd0, exec_op}, 16'(exec_len)));
                exec_len = 0;
            end
            if (dmem_req) begin
                if (!prev_dmem) begin
                    mem_a = {dmem_we, sel_imm, sel_mem, alu_op, rf_rd, rf_rs};
                    mem_addr = imem_addr;
                end
                mem_len++;
            end else if (prev_dmem) begin
                check_ev("mem", mk(EV_MEM, mem_a, {mem_addr, 8'(mem_len)}));
                mem_len = 0;
            end
            if (rf_we)
                check_ev("wb", mk(EV_WB, {1'b0, sel_imm, sel_mem, alu_op, rf_rd, rf_rs}, {imem_addr, retired[7:0]}));
            if (halted && !prev_halted)
                check_ev("halt", mk(EV_HALT, {imem_req, dmem_req, rf_we, sel_imm, sel_mem, alu_op, 6'd0, trap_cause},
                                    {imem_addr, retired[7:0]}));
            prev_dmem = dmem_req;
            prev_halted = halted;
        end
    end

    task automatic do_reset(input logic [31:0] fill);
        rst_n = 1'b0;
        run = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) prog[i] = fill;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", 64'({imem_req, imem_addr, dmem_req, dmem_we, rf_rs, rf_rt, rf_rd, rf_we, sel_imm,
                                    sel_mem, alu_op, halted, trap_cause, retired, dbg_state}), 64'd0);
    endtask

    task automatic start_run();
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int i;
        i = 0;
        while (!halted && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("halt_reached", 64'(halted), 64'd1);
        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    int rs_t [6] = '{3, 0, 6, 9, 12, 15};
    int fn_t [6] = '{50, 0, 32, 34, 36, 37};
    int op_t [6] = '{3, 0, 1, 2, 4, 5};

    initial begin
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'd0;

        // LW with fetch wait 2 and data wait 1
        do_reset(ILL);
        prog[0] = {6'd7, 5'd1, 5'd2, 16'd4};
        imem_lat = 2; dmem_lat = 1;
        exp_q.push_back(ev_exec(3'd1, 1));
        exp_q.push_back(ev_mem(1'b0, 1'b1, 1'b1, 3'd1, 5'd2, 5'd1, 8'd0, 2));
        exp_q.push_back(ev_wb(1'b1, 1'b1, 3'd1, 5'd2, 5'd1, 8'd0, 0));
        exp_q.push_back(ev_halt(2'd1, 8'd1, 1));
        start_run();
        wait_halt(200);

        // SW: store request, no writeback
        do_reset(ILL);
        prog[0] = {6'd8, 5'd1, 5'd2, 16'd0};
        imem_lat = 0; dmem_lat = 0;
        exp_q.push_back(ev_exec(3'd1, 1));
        exp_q.push_back(ev_mem(1'b1, 1'b1, 1'b0, 3'd1, 5'd0, 5'd1, 8'd0, 1));
        exp_q.push_back(ev_halt(2'd1, 8'd1, 1));
        start_run();
        wait_halt(200);

        // ALU ops with a NOP, ended by an illegal funct
        do_reset(ILL);
        imem_lat = 1; dmem_lat = 0;
        for (int i = 0; i < 6; i++) begin
            prog[i] = (op_t[i] == 0) ? 32'd0 : alu_w(rs_t[i], fn_t[i]);
            if (op_t[i] != 0) begin
                exp_q.push_back(ev_exec(3'(op_t[i]), (op_t[i] == 3) ? MULT_LAT : 1));
                exp_q.push_back(ev_wb(1'b0, 1'b0, 3'(op_t[i]), 5'(rs_t[i] + 2), 5'(rs_t[i]), 8'(i), i));
            end
        end
        prog[6] = alu_w(1, 33);
        exp_q.push_back(ev_halt(2'd1, 8'd6, 6));
        start_run();
        wait_halt(400);

        // Opcode 9 traps; halt is sticky under run toggling
        do_reset(ILL);
        prog[0] = {6'd9, 26'd0};
        imem_lat = 0;
        exp_q.push_back(ev_halt(2'd1, 8'd0, 0));
        start_run();
        wait_halt(100);
        for (int i = 0; i < 10; i++) @(negedge clk) run = i[0];
        run = 1'b0;
        repeat (5) @(negedge clk);
        check("halt_sticky", 64'({halted, trap_cause, imem_addr, imem_req, dbg_state}),
              64'({1'b1, 2'd1, 8'd0, 1'b0, S_HALT}));

        // Data memory never answers
        do_reset(ILL);
        prog[0] = {6'd7, 5'd1, 5'd2, 16'd4};
        imem_lat = 0; dmem_lat = NEVER;
        exp_q.push_back(ev_exec(3'd1, 1));
        exp_q.push_back(ev_mem(1'b0, 1'b1, 1'b1, 3'd1, 5'd2, 5'd1, 8'd0, MEM_TIMEOUT));
        exp_q.push_back(ev_halt(2'd3, 8'd0, 0));
        start_run();
        wait_halt(200);

        // Data ack on the last allowed cycle still succeeds
        do_reset(ILL);
        prog[0] = {6'd8, 5'd1, 5'd2, 16'd0};
        imem_lat = 0; dmem_lat = MEM_TIMEOUT - 1;
        exp_q.push_back(ev_exec(3'd1, 1));
        exp_q.push_back(ev_mem(1'b1, 1'b1, 1'b0, 3'd1, 5'd0, 5'd1, 8'd0, MEM_TIMEOUT));
        exp_q.push_back(ev_halt(2'd1, 8'd1, 1));
        start_run();
        wait_halt(200);

        // Instruction memory never answers
        do_reset(ILL);
        imem_lat = NEVER;
        exp_q.push_back(ev_halt(2'd2, 8'd0, 0));
        start_run();
        wait_halt(100);

        // Reset asserted mid-MEM drops everything at once
        do_reset(ILL);
        prog[0] = {6'd7, 5'd1, 5'd2, 16'd4};
        imem_lat = 0; dmem_lat = NEVER;
        exp_q.push_back(ev_exec(3'd1, 1));
        start_run();
        for (int i = 0; i < 50 && !dmem_req; i++) @(negedge clk);
        check("mem_entered", 64'(dmem_req), 64'd1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 64'({imem_req, imem_addr, dmem_req, dmem_we, rf_rs, rf_rt, rf_rd, rf_we,
                                             sel_imm, sel_mem, alu_op, halted, trap_cause, retired, dbg_state}), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // 256 NOPs: PC wraps exactly when retired reaches 256
        do_reset(32'd0);
        imem_lat = 0;
        start_run();
        for (int i = 0; i < 3000 && !(imem_addr == 8'd0 && retired != 16'd0); i++) @(negedge clk);
        check("nop_wrap_retired", 64'(retired), 64'd256);
        check("nop_wrap_pc", 64'(imem_addr), 64'd0);
        check("nop_no_events", 64'(exp_q.size()), 64'd0);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
